// File: rtl/vscale_htif_pkg.sv
// Shared HTIF controller types: FSM encoding, default tohost address,
// PCR width and the tohost/fromhost CSR addresses of the vscale CSR map.
package vscale_htif_pkg;

  localparam int          HTIF_PCR_WIDTH      = 64;
  localparam logic [11:0] CSR_ADDR_TO_HOST    = 12'h780;
  localparam logic [11:0] CSR_ADDR_FROM_HOST  = 12'h781;
  localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } htif_state_t;

endpackage

// File: rtl/vscale_tohost_fifo.sv
// Tohost FIFO: a push is visible at head one cycle later, and pop reads head.
// It ignores push when full and pop when empty. Pointers carry one wrap bit.
module vscale_tohost_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/vscale_htif_ctrl.sv
// HTIF controller: it queues core tohost stores, serves PCR tohost/fromhost one request
// at a time, and decodes the riscv-tests pass/fail word into sticky status.
module vscale_htif_ctrl
  import vscale_htif_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR = DEFAULT_TOHOST_ADDR,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      core_wr_valid,
  input  logic [31:0]               core_wr_addr,
  input  logic [31:0]               core_wr_data,
  output logic                      core_wr_ready,
  output logic                      fromhost_valid,
  output logic [HTIF_PCR_WIDTH-1:0] fromhost_data,
  input  logic                      fromhost_ack,
  input  logic                      htif_pcr_req_valid,
  output logic                      htif_pcr_req_ready,
  input  logic                      htif_pcr_req_rw,
  input  logic [11:0]               htif_pcr_req_addr,
  input  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data,
  output logic                      htif_pcr_resp_valid,
  input  logic                      htif_pcr_resp_ready,
  output logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data,
  output logic                      test_done,
  output logic                      test_pass,
  output logic [30:0]               test_code
);

  htif_state_t               state;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [HTIF_PCR_WIDTH-1:0] fifo_head;
  logic                      is_tohost;
  logic                      push;
  logic                      pop;
  logic                      req_fire;
  logic                      wr_fromhost;
  logic [HTIF_PCR_WIDTH-1:0] rd_data;

  assign is_tohost     = (core_wr_addr == TOHOST_ADDR);
  assign core_wr_ready = !(is_tohost && fifo_full);
  assign push          = core_wr_valid && is_tohost && (core_wr_data != 32'd0) && !fifo_full;

  assign req_fire    = htif_pcr_req_valid && (state == IDLE);
  assign pop         = req_fire && !htif_pcr_req_rw &&
                       (htif_pcr_req_addr == CSR_ADDR_TO_HOST) && !fifo_empty;
  assign wr_fromhost = req_fire && htif_pcr_req_rw && (htif_pcr_req_addr == CSR_ADDR_FROM_HOST);

  always_comb begin
    rd_data = '0;
    if (!htif_pcr_req_rw) begin
      if (htif_pcr_req_addr == CSR_ADDR_TO_HOST && !fifo_empty) begin
        rd_data = fifo_head;
      end else if (htif_pcr_req_addr == CSR_ADDR_FROM_HOST) begin
        rd_data = fromhost_data;
      end
    end
  end

  vscale_tohost_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (HTIF_PCR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({{(HTIF_PCR_WIDTH-32){1'b0}}, core_wr_data}),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      htif_pcr_req_ready  <= 1'b1;
      htif_pcr_resp_valid <= 1'b0;
      htif_pcr_resp_data  <= '0;
    end else begin
      case (state)
        IDLE: if (req_fire) begin
          state               <= RESP;
          htif_pcr_req_ready  <= 1'b0;
          htif_pcr_resp_valid <= 1'b1;
          htif_pcr_resp_data  <= rd_data;
        end
        RESP: if (htif_pcr_resp_ready) begin
          state               <= IDLE;
          htif_pcr_req_ready  <= 1'b1;
          htif_pcr_resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A host write has priority over a core ack that lands in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      fromhost_valid <= 1'b0;
      fromhost_data  <= '0;
    end else if (wr_fromhost) begin
      fromhost_valid <= 1'b1;
      fromhost_data  <= htif_pcr_req_data;
    end else if (fromhost_ack && fromhost_valid) begin
      fromhost_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      test_done <= 1'b0;
      test_pass <= 1'b0;
      test_code <= '0;
    end else if (push && !test_done) begin
      test_done <= 1'b1;
      test_pass <= (core_wr_data == 32'd1);
      test_code <= (core_wr_data == 32'd1) ? 31'd0 : core_wr_data[31:1];
    end
  end

endmodule

// File: tb/tb_vscale_htif_ctrl.sv
// Bench for vscale_htif_ctrl: a tohost FIFO model and a response scoreboard
// supply every expected value.
module tb_vscale_htif_ctrl;
  import vscale_htif_pkg::*;

  localparam logic [31:0] TH = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        core_wr_valid = 1'b0;
  logic [31:0] core_wr_addr = TH;
  logic [31:0] core_wr_data = '0;
  logic        core_wr_ready;
  logic        fromhost_valid;
  logic [63:0] fromhost_data;
  logic        fromhost_ack = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw = 1'b0;
  logic [11:0] req_addr = '0;
  logic [63:0] req_data = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_data;
  logic        test_done;
  logic        test_pass;
  logic [30:0] test_code;

  int n_tests = 0;
  int n_fail = 0;
  logic [63:0] model_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] fh_model = '0;

  vscale_htif_ctrl dut (
    .clk                 (clk),
    .reset               (reset),
    .core_wr_valid       (core_wr_valid),
    .core_wr_addr        (core_wr_addr),
    .core_wr_data        (core_wr_data),
    .core_wr_ready       (core_wr_ready),
    .fromhost_valid      (fromhost_valid),
    .fromhost_data       (fromhost_data),
    .fromhost_ack        (fromhost_ack),
    .htif_pcr_req_valid  (req_valid),
    .htif_pcr_req_ready  (req_ready),
    .htif_pcr_req_rw     (req_rw),
    .htif_pcr_req_addr   (req_addr),
    .htif_pcr_req_data   (req_data),
    .htif_pcr_resp_valid (resp_valid),
    .htif_pcr_resp_ready (resp_ready),
    .htif_pcr_resp_data  (resp_data),
    .test_done           (test_done),
    .test_pass           (test_pass),
    .test_code           (test_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    model_q.delete();
    exp_q.delete();
    fh_model = '0;
  endtask

  task automatic core_store(input logic [31:0] addr, input logic [31:0] data);
    int budget;
    @(negedge clk);
    core_wr_valid = 1'b1;
    core_wr_addr  = addr;
    core_wr_data  = data;
    budget = 0;
    while (!core_wr_ready && budget < 30) begin
      @(negedge clk);
      budget++;
    end
    if (!core_wr_ready) begin
      check("store_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge clk);
      if (addr == TH && data != 32'd0) model_q.push_back({32'd0, data});
    end
    #1 core_wr_valid = 1'b0;
  endtask

  task automatic htif_txn(input logic rw, input logic [11:0] addr, input logic [63:0] wdata,
                          input int hold);
    logic [63:0] exp;
    int budget;
    exp = '0;
    if (!rw && addr == CSR_ADDR_TO_HOST && model_q.size() > 0) exp = model_q.pop_front();
    if (!rw && addr == CSR_ADDR_FROM_HOST) exp = fh_model;
    exp_q.push_back(exp);
    @(negedge clk);
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_data  = wdata;
    check("req_rdy_idle", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    if (rw && addr == CSR_ADDR_FROM_HOST) fh_model = wdata;
    #1 req_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("resp_vld_hold", {63'd0, resp_valid}, 64'd1);
      check("req_rdy_busy", {63'd0, req_ready}, 64'd0);
      check("resp_dat_hold", resp_data, exp_q[0]);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    budget = 0;
    while (!resp_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!resp_valid) begin
      check("resp_timeout", 64'd0, 64'd1);
      void'(exp_q.pop_front());
    end else begin
      check("resp_dat", resp_data, exp_q.pop_front());
    end
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_req_rdy", {63'd0, req_ready}, 64'd1);
    check("rst_resp_vld", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_dat", resp_data, 64'd0);
    check("rst_fh_vld", {63'd0, fromhost_valid}, 64'd0);
    check("rst_fh_dat", fromhost_data, 64'd0);
    check("rst_wr_rdy", {63'd0, core_wr_ready}, 64'd1);
    check("rst_status", {31'd0, test_done, test_pass, test_code}, 64'd0);

    core_store(TH, 32'd1);
    check("pass_done", {63'd0, test_done}, 64'd1);
    check("pass_pass", {63'd0, test_pass}, 64'd1);
    htif_txn(1'b0, CSR_ADDR_TO_HOST, '0, 0);
    htif_txn(1'b0, CSR_ADDR_TO_HOST, '0, 0);

    do_reset();
    core_store(TH, 32'h2A);
    check("fail_done", {63'd0, test_done}, 64'd1);
    check("fail_pass", {63'd0, test_pass}, 64'd0);
    check("fail_code", {33'd0, test_code}, 64'd21);
    core_store(TH, 32'd1);
    check("sticky_pass", {63'd0, test_pass}, 64'd0);
    check("sticky_code", {33'd0, test_code}, 64'd21);
    htif_txn(1'b0, CSR_ADDR_TO_HOST, '0, 0);
    htif_txn(1'b0, CSR_ADDR_TO_HOST, '0, 0);

    core_store(TH, 32'd0);
    core_store(32'h0000_2000, 32'h77);
    htif_txn(1'b0, CSR_ADDR_TO_HOST, '0, 0);

    for (int i = 1; i <= 4; i++) core_store(TH, i);
    fork
      core_store(TH, 32'd5);
      begin
        @(negedge clk);
        #1 check("full_wr_rdy", {63'd0, core_wr_ready}, 64'd0);
        htif_txn(1'b0, CSR_ADDR_TO_HOST, '0, 0);
      end
    join
    @(negedge clk);
    core_wr_addr = TH;
    #1 check("refull_wr_rdy", {63'd0, core_wr_ready}, 64'd0);
    core_wr_addr = 32'h0000_2000;
    #1 check("full_other_rdy", {63'd0, core_wr_ready}, 64'd1);
    core_wr_addr = TH;
    for (int i = 0; i < 5; i++) htif_txn(1'b0, CSR_ADDR_TO_HOST, '0, 0);

    htif_txn(1'b1, CSR_ADDR_FROM_HOST, 64'hDEAD, 3);
    @(negedge clk);
    check("fh_vld_set", {63'd0, fromhost_valid}, 64'd1);
    check("fh_dat_set", fromhost_data, 64'hDEAD);
    htif_txn(1'b0, CSR_ADDR_FROM_HOST, '0, 0);
    @(negedge clk);
    fromhost_ack = 1'b1;
    @(posedge clk);
    #1 fromhost_ack = 1'b0;
    @(negedge clk);
    check("fh_ack_clr", {63'd0, fromhost_valid}, 64'd0);
    htif_txn(1'b1, CSR_ADDR_FROM_HOST, 64'h1111, 0);
    fork
      htif_txn(1'b1, CSR_ADDR_FROM_HOST, 64'hBEEF, 0);
      begin
        @(negedge clk);
        fromhost_ack = 1'b1;
        @(posedge clk);
        #1 fromhost_ack = 1'b0;
      end
    join
    @(negedge clk);
    check("fh_wr_wins_vld", {63'd0, fromhost_valid}, 64'd1);
    check("fh_wr_wins_dat", fromhost_data, 64'hBEEF);
    htif_txn(1'b1, CSR_ADDR_TO_HOST, 64'h5555, 0);
    htif_txn(1'b0, 12'h123, '0, 0);
    htif_txn(1'b0, CSR_ADDR_FROM_HOST, '0, 0);

    core_store(TH, 32'd7);
    core_store(TH, 32'd8);
    @(negedge clk);
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_addr  = CSR_ADDR_FROM_HOST;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("mid_resp_vld", {63'd0, resp_valid}, 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_q.delete();
    fh_model = '0;
    @(negedge clk);
    check("rst_mid_resp_vld", {63'd0, resp_valid}, 64'd0);
    check("rst_mid_req_rdy", {63'd0, req_ready}, 64'd1);
    check("rst_mid_fh_vld", {63'd0, fromhost_valid}, 64'd0);
    check("rst_mid_done", {63'd0, test_done}, 64'd0);
    htif_txn(1'b0, CSR_ADDR_TO_HOST, '0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
